sisc_mc_core: RTL and testbench

//  Parametrised multi-cycle SISC execution core: RF, ALU, status register and control FSM in one block.

---
 rtl/sisc_mc_core.sv | 191 +++++++++++++++++++
 tb/tb_sisc_mc_core.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sisc_mc_core.sv
// Multi-cycle SISC core: register file, ALU, status flags and IDLE/DECODE/EXEC/WB sequencer.
// Optional build macro SISC_ADDC_EN adds ADC (mm 8) and SBC (mm 9) for R-type instructions.
`timescale 1ns/1ps
module sisc_mc_core #(
  parameter int DWIDTH = 32,
  parameter int NREGS  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ir_valid,
  output logic              ir_ready,
  input  logic [31:0]       ir,
  output logic              busy,
  output logic              halted,
  output logic              illegal,
  output logic [3:0]        stat,
  output logic              wb_en,
  output logic [3:0]        wb_reg,
  output logic [DWIDTH-1:0] wb_data,
  input  logic [3:0]        dbg_addr,
  output logic [DWIDTH-1:0] dbg_data
);

  localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;

`ifdef SISC_ADDC_EN
  localparam logic [3:0] MM_MAX_R = 4'd9;
`else
  localparam logic [3:0] MM_MAX_R = 4'd7;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALTED
  } state_t;

  state_t            state_q;
  logic [31:0]       ir_q;
  logic [DWIDTH-1:0] op_a_q, op_b_q;
  logic [3:0]        flags_q;
  logic              ready_q, busy_q, halted_q, illegal_q, wb_en_q;
  logic [3:0]        stat_q, wb_reg_q;
  logic [DWIDTH-1:0] wb_data_q;
  logic [DWIDTH-1:0] rf_q [NREGS];

  logic [3:0] opc, mm, rd, rs, rt;
  logic [DWIDTH-1:0] imm_sext;

  assign opc      = ir_q[31:28];
  assign mm       = ir_q[27:24];
  assign rd       = ir_q[23:20];
  assign rs       = ir_q[19:16];
  assign rt       = ir_q[15:12];
  assign imm_sext = DWIDTH'($signed(ir_q[15:0]));

  // Index 0 and unimplemented indices always read as zero.
  function automatic logic [DWIDTH-1:0] rf_read(input logic [3:0] idx);
    if (idx == 4'd0 || int'(idx) >= NREGS) return '0;
    return rf_q[idx[IW-1:0]];
  endfunction

  logic is_alu_d, is_illegal_d;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    is_alu_d     = 1'b0;
    is_illegal_d = 1'b0;
    case (opc)
      4'h0, 4'hF: ;
      4'h1: if (mm <= MM_MAX_R) is_alu_d = 1'b1; else is_illegal_d = 1'b1;
      4'h2: if (mm <= 4'd4)     is_alu_d = 1'b1; else is_illegal_d = 1'b1;
      default: is_illegal_d = 1'b1;
    endcase
  end

  logic [DWIDTH-1:0] addend, res_d;
  logic [DWIDTH:0]   sum;
  logic              arith, cin, c_d, v_d;
  logic [3:0]        flags_d;

  always_comb begin
    arith  = 1'b0;
    addend = op_b_q;
    cin    = 1'b0;
    res_d  = '0;
    c_d    = 1'b0;
    v_d    = 1'b0;
    case (mm)
      4'd0: arith = 1'b1;
      4'd1: begin arith = 1'b1; addend = ~op_b_q; cin = 1'b1; end
`ifdef SISC_ADDC_EN
      4'd8: begin arith = 1'b1; cin = stat_q[3]; end
      4'd9: begin arith = 1'b1; addend = ~op_b_q; cin = stat_q[3]; end
`endif
      4'd2: res_d = op_a_q & op_b_q;
      4'd3: res_d = op_a_q | op_b_q;
      4'd4: res_d = op_a_q ^ op_b_q;
      4'd5: res_d = ~op_a_q;
      4'd6: begin res_d = op_a_q << 1; c_d = op_a_q[DWIDTH-1]; end
      4'd7: begin res_d = op_a_q >> 1; c_d = op_a_q[0]; end
      default: ;
    endcase
    sum = {1'b0, op_a_q} + {1'b0, addend} + {{DWIDTH{1'b0}}, cin};
    if (arith) begin
      res_d = sum[DWIDTH-1:0];
      c_d   = sum[DWIDTH];
      v_d   = (op_a_q[DWIDTH-1] == addend[DWIDTH-1]) && (res_d[DWIDTH-1] != op_a_q[DWIDTH-1]);
    end
    flags_d = {c_d, v_d, res_d[DWIDTH-1], res_d == '0};
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      flags_q   <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      stat_q    <= '0;
      wb_en_q   <= 1'b0;
      wb_reg_q  <= '0;
      wb_data_q <= '0;
      // NOTE: the register file is architecturally zeroed by reset, so it is built from flops, not RAM.
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (ir_valid) begin
          ir_q    <= ir;
          ready_q <= 1'b0;
          busy_q  <= 1'b1;
          state_q <= S_DECODE;
        end
        S_DECODE: if (opc == 4'hF) begin
          halted_q <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= S_HALTED;
        end else begin
          op_a_q  <= rf_read(rs);
          op_b_q  <= (opc == 4'h2) ? imm_sext : rf_read(rt);
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          wb_en_q <= is_alu_d;
          if (is_alu_d) begin
            wb_reg_q  <= rd;
            wb_data_q <= res_d;
            flags_q   <= flags_d;
          end
          if (is_illegal_d) illegal_q <= 1'b1;
          state_q <= S_WB;
        end
        S_WB: begin
          wb_en_q <= 1'b0;
          // Flags update even when the destination index is dropped.
          if (wb_en_q) begin
            stat_q <= flags_q;
            if (wb_reg_q != 4'd0 && int'(wb_reg_q) < NREGS) rf_q[wb_reg_q[IW-1:0]] <= wb_data_q;
          end
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        S_HALTED: ;
        default: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ir_ready = ready_q;
  assign busy     = busy_q;
  assign halted   = halted_q;
  assign illegal  = illegal_q;
  assign stat     = stat_q;
  assign wb_en    = wb_en_q;
  assign wb_reg   = wb_reg_q;
  assign wb_data  = wb_data_q;
  assign dbg_data = rf_read(dbg_addr);

endmodule

// File: tb/tb_sisc_mc_core.sv
// Directed bench for sisc_mc_core (DWIDTH=32, NREGS=16); honours SISC_ADDC_EN when defined.
`timescale 1ns/1ps
module tb_sisc_mc_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ir_valid = 1'b0;
  logic        ir_ready;
  logic [31:0] ir = '0;
  logic        busy, halted, illegal, wb_en;
  logic [3:0]  stat, wb_reg;
  logic [31:0] wb_data, dbg_data;
  logic [3:0]  dbg_addr = '0;

  int total = 0;
  int bad   = 0;

  sisc_mc_core #(.DWIDTH(32), .NREGS(16)) dut (
    .clk(clk), .rst(rst), .ir_valid(ir_valid), .ir_ready(ir_ready), .ir(ir),
    .busy(busy), .halted(halted), .illegal(illegal), .stat(stat),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ir;
    logic        wb;
    logic [3:0]  rd;
    logic [31:0] data;
    logic [3:0]  stat;
    logic        ill;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic dbg_check(input logic [3:0] idx, input logic [31:0] exp);
    dbg_addr = idx;
    #1;
    check($sformatf("R%0d", idx), dbg_data, exp);
  endtask

  // Caller sits just after a rising edge; returns just after the edge that ends WB.
  task automatic apply(input logic [31:0] instr, input logic exp_wb,
                       input logic [3:0] exp_reg, input logic [31:0] exp_data);
    int waited = 0;
    while (!ir_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check("ready_before_issue", ir_ready, 1);
    ir = instr;
    ir_valid = 1'b1;
    @(posedge clk); #1;
    ir_valid = 1'b0;
    ir = '0;
    check("busy_after_accept", busy, 1);
    check("ready_after_accept", ir_ready, 0);
    @(posedge clk); #1;
    check("wb_en_decode", wb_en, 0);
    @(posedge clk); #1;
    check($sformatf("wb_en_%08h", instr), wb_en, exp_wb);
    if (exp_wb) begin
      check($sformatf("wb_reg_%08h", instr), wb_reg, exp_reg);
      check($sformatf("wb_data_%08h", instr), wb_data, exp_data);
    end
    @(posedge clk); #1;
    check("wb_en_after_wb", wb_en, 0);
    check("ready_after_wb", ir_ready, 1);
    check("busy_after_wb", busy, 0);
  endtask

  task automatic pulse_reset();
    ir_valid = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{32'h2010_0005, 1'b1, 4'd1, 32'h0000_0005, 4'b0000, 1'b0};
    vecs[1]  = '{32'h2020_FFFF, 1'b1, 4'd2, 32'hFFFF_FFFF, 4'b0010, 1'b0};
    vecs[2]  = '{32'h2010_FFFF, 1'b1, 4'd1, 32'hFFFF_FFFF, 4'b0010, 1'b0};
    vecs[3]  = '{32'h1711_0000, 1'b1, 4'd1, 32'h7FFF_FFFF, 4'b1000, 1'b0};
    vecs[4]  = '{32'h2020_0001, 1'b1, 4'd2, 32'h0000_0001, 4'b0000, 1'b0};
    vecs[5]  = '{32'h1031_2000, 1'b1, 4'd3, 32'h8000_0000, 4'b0110, 1'b0};
    vecs[6]  = '{32'h1141_1000, 1'b1, 4'd4, 32'h0000_0000, 4'b1001, 1'b0};
    vecs[7]  = '{32'h1252_3000, 1'b1, 4'd5, 32'h0000_0000, 4'b0001, 1'b0};
    vecs[8]  = '{32'h1353_2000, 1'b1, 4'd5, 32'h8000_0001, 4'b0010, 1'b0};
    vecs[9]  = '{32'h1455_1000, 1'b1, 4'd5, 32'hFFFF_FFFE, 4'b0010, 1'b0};
    vecs[10] = '{32'h1565_0000, 1'b1, 4'd6, 32'h0000_0001, 4'b0000, 1'b0};
    vecs[11] = '{32'h1673_0000, 1'b1, 4'd7, 32'h0000_0000, 4'b1001, 1'b0};
    vecs[12] = '{32'h0000_0000, 1'b0, 4'd0, 32'h0000_0000, 4'b1001, 1'b0};
    vecs[13] = '{32'h2181_0001, 1'b1, 4'd8, 32'h7FFF_FFFE, 4'b1000, 1'b0};
    vecs[14] = '{32'h2591_0000, 1'b0, 4'd0, 32'h0000_0000, 4'b1000, 1'b1};
    vecs[15] = '{32'h2000_0009, 1'b1, 4'd0, 32'h0000_0009, 4'b0000, 1'b1};
    vecs[16] = '{32'h2090_7FFF, 1'b1, 4'd9, 32'h0000_7FFF, 4'b0000, 1'b1};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_ready", ir_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_halted", halted, 0);
    check("reset_illegal", illegal, 0);
    check("reset_stat", stat, 0);
    check("reset_wb_en", wb_en, 0);
    check("reset_wb_reg", wb_reg, 0);
    check("reset_wb_data", wb_data, 0);
    for (int i = 0; i < 16; i++) dbg_check(4'(i), 32'h0);
    @(posedge clk); #1;

    for (int i = 0; i < 17; i++) begin
      apply(vecs[i].ir, vecs[i].wb, vecs[i].rd, vecs[i].data);
      check($sformatf("stat_v%0d", i), stat, vecs[i].stat);
      check($sformatf("illegal_v%0d", i), illegal, vecs[i].ill);
      if (vecs[i].wb) dbg_check(vecs[i].rd, (vecs[i].rd == 4'd0) ? 32'h0 : vecs[i].data);
    end

    // Reset while an ADD into R5 sits in EXEC: no writeback, clean restart.
    @(posedge clk); #1;
    ir = 32'h1051_2000;
    ir_valid = 1'b1;
    @(posedge clk); #1;
    ir_valid = 1'b0;
    @(posedge clk); #1;
    pulse_reset();
    check("abort_wb_en", wb_en, 0);
    check("abort_ready", ir_ready, 1);
    check("abort_stat", stat, 0);
    dbg_check(4'd5, 32'h0);
    @(posedge clk); #1;
    check("abort_wb_en_next", wb_en, 0);
    check("abort_busy_next", busy, 0);

    // Undefined opcode, then HALT with a following instruction held valid.
    apply(32'h7000_0000, 1'b0, 4'd0, 32'h0);
    check("op7_illegal", illegal, 1);
    check("op7_stat", stat, 0);
    ir = 32'hF000_0000;
    ir_valid = 1'b1;
    @(posedge clk); #1;
    ir = 32'h2010_0005;
    @(posedge clk); #1;
    check("halt_halted", halted, 1);
    check("halt_busy", busy, 0);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("halt_ready_c%0d", i), ir_ready, 0);
      check($sformatf("halt_wb_en_c%0d", i), wb_en, 0);
      @(posedge clk); #1;
    end
    pulse_reset();
    check("halt_rst_halted", halted, 0);
    check("halt_rst_illegal", illegal, 0);
    check("halt_rst_ready", ir_ready, 1);
    dbg_check(4'd1, 32'h0);
    @(posedge clk); #1;

    // Add-with-carry: C is set by SHR1 of R1 into R0.
    apply(32'h2010_0001, 1'b1, 4'd1, 32'h1);
    apply(32'h2020_0002, 1'b1, 4'd2, 32'h2);
    apply(32'h1701_0000, 1'b1, 4'd0, 32'h0);
    check("carry_setup_stat", stat, 4'b1001);
`ifdef SISC_ADDC_EN
    apply(32'h1831_2000, 1'b1, 4'd3, 32'h4);
    check("adc_stat", stat, 4'b0000);
    check("adc_illegal", illegal, 0);
    dbg_check(4'd3, 32'h4);
`else
    apply(32'h1831_2000, 1'b0, 4'd0, 32'h0);
    check("adc_illegal", illegal, 1);
    check("adc_stat", stat, 4'b1001);
    dbg_check(4'd3, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
